// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: Coprocessor-0 exception responder for the five-stage MIPS pipeline.
// Holds SR (12), Cause (13), EPC (14), PRId (15) and, when CP0_BADVADDR_EN is
// defined, BadVAddr (8). Raises the combinational flush request Req for
// interrupts and M-stage exceptions, records the victim state on the Req edge,
// and serves mfc0/mtc0/eret.
// Optional feature macro: CP0_BADVADDR_EN (register 8 present when defined).

module cp0_exc_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h2024_0007,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CP0WriteM,
  input  logic [4:0]  CP0AddrM,
  input  logic [31:0] CP0InM,
  input  logic [31:0] PCForTestM,
  input  logic        DelaySlotM,
  input  logic [4:0]  FixEXCM,
  input  logic        ERETM,
  input  logic [31:0] BadVAddrInM,
  input  logic [5:0]  HWInt,
  output logic [31:0] CP0OutM,
  output logic [31:0] EPCOut,
  output logic [31:0] HandlerPC,
  output logic        Req
);

  // CP0 register numbers decoded by this unit
  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_SR       = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;

  // Exception code meaning "no exception" in the M stage
  localparam logic [4:0] EXC_NONE = 5'h1F;
  // Exception code recorded when an interrupt is taken
  localparam logic [4:0] EXC_INT  = 5'd0;
  // Address-error codes that capture the faulting address
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // SR fields
  logic [5:0]  sr_im_reg,  sr_im_next;
  logic        sr_exl_reg, sr_exl_next;
  logic        sr_ie_reg,  sr_ie_next;

  // Cause fields
  logic        cause_bd_reg,  cause_bd_next;
  logic [5:0]  cause_ip_reg,  cause_ip_next;
  logic [4:0]  cause_exc_reg, cause_exc_next;

  // Exception PC
  logic [31:0] epc_reg, epc_next;

  // Request terms and helpers
  logic        int_req;
  logic        exc_req;
  logic        take_req;
  logic [4:0]  exc_code;
  logic [31:0] victim_pc;
  logic        write_sr;
  logic        write_epc;

  // Read views of the composite registers
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;
  logic [31:0] bad_vaddr_rd;

  // Interrupt and exception request decode; EXL masks both
  always_comb begin
    int_req   = (|(HWInt & sr_im_reg)) & sr_ie_reg & ~sr_exl_reg;
    exc_req   = (FixEXCM != EXC_NONE) & ~sr_exl_reg;
    take_req  = int_req | exc_req;
    // Interrupt wins over a simultaneous exception
    exc_code  = int_req ? EXC_INT : FixEXCM;
    // A delay-slot victim must restart at its branch, one word earlier
    victim_pc = DelaySlotM ? (PCForTestM - 32'd4) : PCForTestM;
    write_sr  = CP0WriteM & (CP0AddrM == ADDR_SR);
    write_epc = CP0WriteM & (CP0AddrM == ADDR_EPC);
  end

  // Flush request; held low while reset is asserted
  assign Req       = rst & take_req;
  assign HandlerPC = HANDLER_PC;

  // Next-state for SR, Cause and EPC: Req edge beats mtc0, ERET clear follows SR write
  always_comb begin
    sr_im_next     = sr_im_reg;
    sr_exl_next    = sr_exl_reg;
    sr_ie_next     = sr_ie_reg;
    cause_bd_next  = cause_bd_reg;
    cause_exc_next = cause_exc_reg;
    epc_next       = epc_reg;
    // Pending lines are sampled every edge regardless of anything else
    cause_ip_next  = HWInt;

    if (take_req) begin
      sr_exl_next    = 1'b1;
      cause_bd_next  = DelaySlotM;
      cause_exc_next = exc_code;
      epc_next       = victim_pc;
    end else begin
      if (write_sr) begin
        sr_im_next  = CP0InM[15:10];
        sr_exl_next = CP0InM[1];
        sr_ie_next  = CP0InM[0];
      end
      if (write_epc) begin
        epc_next = CP0InM;
      end
      if (ERETM) begin
        sr_exl_next = 1'b0;
      end
    end
  end

  // SR, Cause and EPC state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_im_reg     <= 6'd0;
      sr_exl_reg    <= 1'b0;
      sr_ie_reg     <= 1'b0;
      cause_bd_reg  <= 1'b0;
      cause_ip_reg  <= 6'd0;
      cause_exc_reg <= 5'd0;
      epc_reg       <= 32'd0;
    end else begin
      sr_im_reg     <= sr_im_next;
      sr_exl_reg    <= sr_exl_next;
      sr_ie_reg     <= sr_ie_next;
      cause_bd_reg  <= cause_bd_next;
      cause_ip_reg  <= cause_ip_next;
      cause_exc_reg <= cause_exc_next;
      epc_reg       <= epc_next;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] bad_vaddr_reg, bad_vaddr_next;
  logic        load_bad_vaddr;

  // Capture the faulting address only for a taken address-error exception
  always_comb begin
    load_bad_vaddr = take_req & ((exc_code == EXC_ADEL) | (exc_code == EXC_ADES));
    bad_vaddr_next = load_bad_vaddr ? BadVAddrInM : bad_vaddr_reg;
  end

  // BadVAddr state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bad_vaddr_reg <= 32'd0;
    end else begin
      bad_vaddr_reg <= bad_vaddr_next;
    end
  end

  assign bad_vaddr_rd = bad_vaddr_reg;
`else
  // Register 8 is absent: it reads zero and the faulting address is dropped
  logic unused_bad_vaddr;
  assign unused_bad_vaddr = ^BadVAddrInM;
  assign bad_vaddr_rd     = 32'd0;
`endif

  // Assemble the architectural views of SR and Cause
  always_comb begin
    sr_rd          = 32'd0;
    sr_rd[15:10]   = sr_im_reg;
    sr_rd[1]       = sr_exl_reg;
    sr_rd[0]       = sr_ie_reg;
    cause_rd       = 32'd0;
    cause_rd[31]   = cause_bd_reg;
    cause_rd[15:10] = cause_ip_reg;
    cause_rd[6:2]  = cause_exc_reg;
  end

  // mfc0 read mux: registered state only, no write-through
  always_comb begin
    CP0OutM = 32'd0;
    case (CP0AddrM)
      ADDR_BADVADDR: CP0OutM = bad_vaddr_rd;
      ADDR_SR:       CP0OutM = sr_rd;
      ADDR_CAUSE:    CP0OutM = cause_rd;
      ADDR_EPC:      CP0OutM = epc_reg;
      ADDR_PRID:     CP0OutM = PRID_VALUE;
      default:       CP0OutM = 32'd0;
    endcase
  end

  // eret return address, forwarding an mtc0 to EPC in the same cycle
  always_comb begin
    EPCOut = epc_reg;
    if (write_epc) begin
      EPCOut = CP0InM;
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: scoreboard bench for cp0_exc_unit. Expected outputs are
// queued as stimulus is driven and compared in the low clock phase.
// Honours CP0_BADVADDR_EN for the register 8 expectations.

module tb_cp0_exc_unit;

  localparam logic [31:0] PRID = 32'h2024_0007;
  localparam logic [31:0] HPC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        CP0WriteM;
  logic [4:0]  CP0AddrM;
  logic [31:0] CP0InM;
  logic [31:0] PCForTestM;
  logic        DelaySlotM;
  logic [4:0]  FixEXCM;
  logic        ERETM;
  logic [31:0] BadVAddrInM;
  logic [5:0]  HWInt;
  logic [31:0] CP0OutM;
  logic [31:0] EPCOut;
  logic [31:0] HandlerPC;
  logic        Req;

  always #5 clk = ~clk;

  cp0_exc_unit #(
    .PRID_VALUE(PRID),
    .HANDLER_PC(HPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .CP0WriteM  (CP0WriteM),
    .CP0AddrM   (CP0AddrM),
    .CP0InM     (CP0InM),
    .PCForTestM (PCForTestM),
    .DelaySlotM (DelaySlotM),
    .FixEXCM    (FixEXCM),
    .ERETM      (ERETM),
    .BadVAddrInM(BadVAddrInM),
    .HWInt      (HWInt),
    .CP0OutM    (CP0OutM),
    .EPCOut     (EPCOut),
    .HandlerPC  (HandlerPC),
    .Req        (Req)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Output selectors for scoreboard entries
  localparam int SEL_REQ = 0;
  localparam int SEL_RD  = 1;
  localparam int SEL_EPC = 2;
  localparam int SEL_HPC = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  // Reference model state
  logic [5:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_bva;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int sel, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic drain();
    sb_item_t it;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.sel)
        SEL_REQ: obs = {31'd0, Req};
        SEL_RD:  obs = CP0OutM;
        SEL_EPC: obs = EPCOut;
        default: obs = HandlerPC;
      endcase
      check_eq(it.tag, obs, it.exp);
    end
  endtask

  task automatic idle();
    CP0WriteM   = 1'b0;
    CP0AddrM    = 5'd0;
    CP0InM      = 32'd0;
    PCForTestM  = HPC;
    DelaySlotM  = 1'b0;
    FixEXCM     = 5'h1F;
    ERETM       = 1'b0;
    BadVAddrInM = 32'd0;
  endtask

  // One idle cycle reading a CP0 register (Req must stay low)
  task automatic read_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    @(negedge clk);
    idle();
    CP0AddrM = addr;
    expect_out({tag, "_req"}, SEL_REQ, 32'd0);
    expect_out(tag, SEL_RD, exp);
    #1 drain();
    $display("[TB] read r%0d tag=%s data=%h", addr, tag, CP0OutM);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8: begin
`ifdef CP0_BADVADDR_EN
        return m_bva;
`else
        return 32'd0;
`endif
      end
      5'd12: return {16'd0, m_im, 8'd0, m_exl, m_ie};
      5'd13: return {m_bd, 15'd0, m_ip, 3'd0, m_exc, 2'd0};
      5'd14: return m_epc;
      5'd15: return PRID;
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] bva_exp;
  logic [31:0] pc_r;
  logic        m_int, m_req;

  initial begin
    idle();
    HWInt   = 6'd0;
    FixEXCM = 5'd4;
`ifdef CP0_BADVADDR_EN
    bva_exp = 32'h0000_7F01;
`else
    bva_exp = 32'd0;
`endif

    // Reset held: exception pending but Req forced low
    #2;
    expect_out("rst_req", SEL_REQ, 32'd0);
    expect_out("hpc", SEL_HPC, HPC);
    #1 drain();
    $display("[TB] reset held, FixEXCM=4, Req=%0b", Req);
    @(negedge clk);
    @(negedge clk);
    idle();
    rst = 1'b1;

    read_reg("rst_sr", 5'd12, 32'd0);
    read_reg("rst_cause", 5'd13, 32'd0);
    read_reg("rst_epc", 5'd14, 32'd0);
    read_reg("prid", 5'd15, PRID);
    read_reg("unmapped", 5'd5, 32'd0);

    // Delay-slot exception, code 10
    @(negedge clk);
    idle();
    FixEXCM = 5'd10; PCForTestM = 32'h0000_3008; DelaySlotM = 1'b1;
    expect_out("exc10_req", SEL_REQ, 32'd1);
    expect_out("exc10_epcout", SEL_EPC, 32'd0);
    #1 drain();
    $display("[TB] exc code 10 in delay slot, Req=%0b", Req);
    read_reg("exc10_cause", 5'd13, 32'h8000_0028);
    read_reg("exc10_epc", 5'd14, 32'h0000_3004);
    read_reg("exc10_sr", 5'd12, 32'h0000_0002);

    // eret with mtc0 EPC in the same cycle: forwarded EPCOut, old read value
    @(negedge clk);
    idle();
    ERETM = 1'b1; CP0WriteM = 1'b1; CP0AddrM = 5'd14; CP0InM = 32'h0000_3100;
    expect_out("eret_req", SEL_REQ, 32'd0);
    expect_out("eret_epcfwd", SEL_EPC, 32'h0000_3100);
    expect_out("eret_nowt", SEL_RD, 32'h0000_3004);
    #1 drain();
    $display("[TB] eret + mtc0 EPC, EPCOut=%h", EPCOut);
    read_reg("eret_sr", 5'd12, 32'd0);
    read_reg("eret_epc", 5'd14, 32'h0000_3100);

    // mtc0 SR <- 0x401 then interrupt coincident with exception 12
    @(negedge clk);
    idle();
    HWInt = 6'b000001; CP0WriteM = 1'b1; CP0AddrM = 5'd12; CP0InM = 32'h0000_0401;
    expect_out("srw_req", SEL_REQ, 32'd0);
    #1 drain();
    $display("[TB] mtc0 SR <- 0x401");
    @(negedge clk);
    idle();
    FixEXCM = 5'd12; PCForTestM = 32'h0000_3200;
    expect_out("int_req", SEL_REQ, 32'd1);
    #1 drain();
    $display("[TB] interrupt + exc 12, Req=%0b", Req);
    read_reg("int_cause", 5'd13, 32'h0000_0400);
    read_reg("int_epc", 5'd14, 32'h0000_3200);
    read_reg("int_sr", 5'd12, 32'h0000_0403);
    @(negedge clk);
    idle();
    FixEXCM = 5'd12; PCForTestM = 32'h0000_3204;
    expect_out("exl_mask", SEL_REQ, 32'd0);
    #1 drain();
    $display("[TB] exception under EXL, Req=%0b", Req);

    // mtc0 to Cause is ignored; IP tracks HWInt
    @(negedge clk);
    idle();
    HWInt = 6'b100100; CP0WriteM = 1'b1; CP0AddrM = 5'd13; CP0InM = 32'hFFFF_FFFF;
    #1 drain();
    $display("[TB] mtc0 Cause <- ffffffff");
    read_reg("cause_ro", 5'd13, 32'h0000_9000);

    // eret, then mtc0 SR coincident with exception 5 (AdES)
    @(negedge clk);
    idle();
    HWInt = 6'd0; ERETM = 1'b1;
    expect_out("eret2_req", SEL_REQ, 32'd0);
    #1 drain();
    $display("[TB] eret");
    @(negedge clk);
    idle();
    CP0WriteM = 1'b1; CP0AddrM = 5'd12; CP0InM = 32'h0000_FC00;
    FixEXCM = 5'd5; PCForTestM = 32'h0000_3300; BadVAddrInM = 32'h0000_7F01;
    expect_out("ades_req", SEL_REQ, 32'd1);
    #1 drain();
    $display("[TB] exc 5 with mtc0 SR, Req=%0b", Req);
    read_reg("ades_sr", 5'd12, 32'h0000_0403);
    read_reg("ades_cause", 5'd13, 32'h0000_0014);
    read_reg("ades_epc", 5'd14, 32'h0000_3300);
    read_reg("badvaddr", 5'd8, bva_exp);

    // Reset asserted mid-handler clears state at once
    @(negedge clk);
    idle();
    rst = 1'b0; HWInt = 6'h3F; FixEXCM = 5'd4;
    for (int a = 12; a <= 14; a++) begin
      CP0AddrM = 5'(a);
      #1;
      expect_out("midrst_req", SEL_REQ, 32'd0);
      expect_out($sformatf("midrst_r%0d", a), SEL_RD, 32'd0);
      drain();
      $display("[TB] reset mid-handler r%0d=%h", a, CP0OutM);
      @(negedge clk);
    end
    idle();
    HWInt = 6'd0;
    rst = 1'b1;
    m_im = 6'd0; m_ip = 6'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
    m_exc = 5'd0; m_epc = 32'd0; m_bva = 32'd0;

    // Randomised traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      CP0WriteM = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: CP0AddrM = 5'd8;
        1, 2: CP0AddrM = 5'd12;
        3: CP0AddrM = 5'd13;
        4: CP0AddrM = 5'd14;
        default: CP0AddrM = 5'($urandom_range(0, 31));
      endcase
      CP0InM = $urandom;
      pc_r = $urandom;
      pc_r[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) pc_r = 32'd0;
      PCForTestM  = pc_r;
      DelaySlotM  = ($urandom_range(0, 1) == 1);
      FixEXCM     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 30)) : 5'h1F;
      ERETM       = ($urandom_range(0, 3) == 0);
      BadVAddrInM = $urandom;
      HWInt       = 6'($urandom_range(0, 63));

      m_int = (|(HWInt & m_im)) & m_ie & ~m_exl;
      m_req = m_int | ((FixEXCM != 5'h1F) & ~m_exl);
      expect_out("rnd_req", SEL_REQ, {31'd0, m_req});
      expect_out("rnd_rd", SEL_RD, m_read(CP0AddrM));
      expect_out("rnd_epcout", SEL_EPC,
                 (CP0WriteM && CP0AddrM == 5'd14) ? CP0InM : m_epc);
      #1 drain();
      $display("[TB] rnd %0d wr=%0b a=%0d exc=%h eret=%0b hw=%h req=%0b",
               n, CP0WriteM, CP0AddrM, FixEXCM, ERETM, HWInt, Req);

      // Model update for the coming edge
      if (m_req) begin
        m_exl = 1'b1;
        m_bd  = DelaySlotM;
        m_exc = m_int ? 5'd0 : FixEXCM;
        m_epc = DelaySlotM ? PCForTestM - 32'd4 : PCForTestM;
        if (m_exc == 5'd4 || m_exc == 5'd5) m_bva = BadVAddrInM;
      end else begin
        if (CP0WriteM && CP0AddrM == 5'd12) begin
          m_im  = CP0InM[15:10];
          m_exl = CP0InM[1];
          m_ie  = CP0InM[0];
        end
        if (CP0WriteM && CP0AddrM == 5'd14) m_epc = CP0InM;
        if (ERETM) m_exl = 1'b0;
      end
      m_ip = HWInt;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Coprocessor-0 exception responder for the five-stage MIPS pipeline. It consumes the exception code, delay-slot flag, victim PC and ERET flag the pipeline registers carry into the M stage, together with the six hardware interrupt lines. It returns the flush request `Req` that every pipeline register obeys, and holds SR, Cause, EPC, PRId and optionally BadVAddr for `mfc0`/`mtc0` and `eret`.

## Interface
- `PRID_VALUE`, default 32'h2024_0007, constant returned by register 15.
- `HANDLER_PC`, default 32'h0000_4180, exception entry address driven on `HandlerPC`.
- `clk` input 1: sole clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `CP0WriteM` input 1: `mtc0` in M stage.
- `CP0AddrM` input 5: CP0 register number (Instr[15:11]).
- `CP0InM` input 32: `mtc0` write data (forwarded rt).
- `PCForTestM` input 32: PC of the M-stage instruction (victim PC).
- `DelaySlotM` input 1: M-stage instruction sits in a branch delay slot.
- `FixEXCM` input 5: exception code; 5'h1F (shared `None` code) means none.
- `ERETM` input 1: `eret` in M stage.
- `BadVAddrInM` input 32: faulting address for AdEL/AdES.
- `HWInt` input 6: external interrupt lines, level-sensitive.
- `CP0OutM` output 32: read data for `CP0AddrM`, combinational.
- `EPCOut` output 32: return address for `eret`, combinational.
- `HandlerPC` output 32: constant `HANDLER_PC`.
- `Req` output 1: flush request, combinational.

## Operation
- SR (12): IM[15:10], EXL[1], IE[0] writable. Other bits read 0; writes to them are ignored.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]. Read-only to software; `mtc0` to 13 is ignored.
- EPC (14): 32 bits, fully writable. PRId (15): reads `PRID_VALUE`. Unmapped numbers read 0.
- Request terms:
  - `IntReq = |(HWInt & IM) & IE & ~EXL`.
  - `ExcReq = (FixEXCM != 5'h1F) & ~EXL`.
  - `Req = IntReq | ExcReq`.
- Register updates on an edge with `Req` = 1:
  - EXL ← 1; Cause.BD ← `DelaySlotM`.
  - Cause.ExcCode ← 0 if `IntReq`, else `FixEXCM`. Interrupt has priority over a simultaneous exception.
  - EPC ← `DelaySlotM` ? `PCForTestM` − 4 : `PCForTestM`, computed modulo 2^32.
  - Any `mtc0` in the same cycle is discarded.
- On an edge with `ERETM` = 1 and `Req` = 0: EXL ← 0.
- On an edge with `CP0WriteM` = 1 and `Req` = 0: write SR or EPC per `CP0AddrM`. If `ERETM` is also 1, ERET's EXL clear is applied after the SR write.
- Cause.IP ← `HWInt` on every edge, unconditionally.
- `EPCOut` forwarding: if `CP0WriteM` && `CP0AddrM` == 14 this cycle, `EPCOut` = `CP0InM`; otherwise it is the EPC register.
- `CP0OutM` reflects register state before the current edge; no write-through.

## Timing
- `Req`, `CP0OutM` and `EPCOut` have zero-cycle latency from their inputs.
- Register updates take effect one edge later.
- A flushed bubble reaching M carries `PCForTestM` = `HANDLER_PC` and code 5'h1F. An interrupt taken on that bubble records EPC = `HANDLER_PC`; this is the decided behaviour.
- After `Req`, EXL = 1 masks further requests until the ERET edge. The next request can be raised in the cycle after the ERET edge.
- Reset asserted, including mid-handler: SR, Cause, EPC and BadVAddr become 0 immediately. `Req` is forced to 0 while `rst` is low.
- Reset release: first edge samples normally. IE = 0, so only exceptions can request.

## Configuration
- `CP0_BADVADDR_EN` defined:
  - Register 8 (BadVAddr, 32 bits, read-only) exists.
  - It loads `BadVAddrInM` on a `Req` edge whose recorded ExcCode is 4 or 5.
  - It resets to 0.
- Undefined: register 8 reads 0 and `BadVAddrInM` is unused.

## Test plan
- Reset low with `FixEXCM` = 4 → `Req` = 0; after release SR, Cause and EPC read 0, PRId reads 32'h2024_0007.
- `FixEXCM` = 10, `PCForTestM` = 0x3008, `DelaySlotM` = 1 → `Req` = 1 same cycle; next cycle Cause = 0x8000_0028, EPC = 0x3004, EXL = 1.
- SR ← 0x0000_0401 via `mtc0`, `HWInt` = 6'b000001, `FixEXCM` = 12 simultaneously → ExcCode = 0; a second exception while EXL = 1 gives `Req` = 0.
- `eret` with `mtc0` EPC ← 0x3100 in the same cycle → `EPCOut` = 0x3100 that cycle; EXL = 0 next cycle.
- `mtc0` to Cause with 0xFFFF_FFFF → Cause unchanged except IP tracking `HWInt`. `mtc0` SR coincident with `Req` → SR keeps EXL = 1 and IM unchanged.
- With `CP0_BADVADDR_EN`, `FixEXCM` = 5, `BadVAddrInM` = 0x7F01 → register 8 reads 0x7F01. Without it, register 8 reads 0.
